ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, meaning CLOCK_50 cycles per sample tick (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 4000, meaning the number of sample ticks without a falling edge before a partial frame is discarded.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PS2_KBCLK  input  1  keyboard clock, asynchronous.
REQ-006 SHALL have port PS2_KBDAT  input  1  keyboard data, asynchronous.
REQ-007 SHALL have port KEY_HELD  output  17  one bit per mapped key; 1 = key currently held.
REQ-008 SHALL have port EVT_VALID  output  1  single-cycle pulse marking a completed make/break event.
REQ-009 SHALL have port EVT_CODE  output  8  scan code of the event; valid with EVT_VALID.
REQ-010 SHALL have port EVT_EXT  output  1  event was E0-prefixed; valid with EVT_VALID.
REQ-011 SHALL have port EVT_RELEASE  output  1  event was F0-prefixed (break); valid with EVT_VALID.
REQ-012 SHALL have port EVT_HIT  output  1  code matched the key map; valid with EVT_VALID.
REQ-013 SHALL have port EVT_INDEX  output  5  key-map index when EVT_HIT=1, else 0.
REQ-014 SHALL have port FRAME_ERR  output  1  single-cycle pulse on a start, stop or parity failure.

Function
REQ-015 SHALL pass PS2_KBCLK and PS2_KBDAT through 2-flop synchronisers before any use.
REQ-016 SHALL generate a one-cycle tick every CLK_DIV cycles; line sampling and the timeout count advance only on ticks.
REQ-017 SHALL detect a falling edge when the synchronised clock is 1 at the previous tick and 0 at the current tick, and SHALL shift the synchronised data into an 11-bit LSB-first register on that edge.
REQ-018 SHALL treat a frame as complete on the 11th falling edge and SHALL check: start=0, stop=1, odd parity over data[7:0] plus the parity bit.
REQ-019 SHALL, on a good frame, present the 8-bit data byte to the decoder on the cycle after completion; on a bad frame, SHALL pulse FRAME_ERR on that cycle, drop the byte, and return the decoder to IDLE.
REQ-020 SHALL clear the bit count when 1-10 bits are held and TIMEOUT_TICKS ticks elapse with no falling edge; no error pulse is generated and the decoder state is unchanged.
REQ-021 SHALL implement decoder states IDLE, EXT, BRK and EXT_BRK. E0 moves IDLE->EXT. F0 moves IDLE->BRK and EXT->EXT_BRK. Any other byte emits an event and returns to IDLE.
REQ-022 SHALL treat E0 received in BRK, or in EXT/EXT_BRK, as a new prefix: the state moves to EXT and no event is emitted; F0 received in BRK or EXT_BRK keeps the current state.
REQ-023 SHALL emit an event by pulsing EVT_VALID for exactly one cycle, 2 CLOCK_50 cycles after the tick that completed the final frame, with EVT_EXT/EVT_RELEASE taken from the state and EVT_CODE equal to the byte.
REQ-024 SHALL use this key map (index: ext,code): 0:1,75; 1:1,72; 2:1,6B; 3:1,74; 4:0,1D; 5:0,1C; 6:0,1B; 7:0,23; 8:0,35; 9:0,34; 10:0,33; 11:0,3B; 12:0,4D; 13:0,4B; 14:0,4C; 15:0,52; 16:0,29. Match requires both the ext flag and the code.
REQ-025 SHALL, on a hit, set KEY_HELD[index] on a make and clear it on a break, in the same cycle EVT_VALID asserts; repeated makes leave the bit set.
REQ-026 SHALL, on a miss, pulse EVT_VALID with EVT_HIT=0 and EVT_INDEX=0, and leave KEY_HELD unchanged.
REQ-027 SHALL hold EVT_CODE, EVT_EXT, EVT_RELEASE, EVT_HIT and EVT_INDEX at their last values between pulses.

Reset
REQ-028 SHALL, while RESET=1 at a clock edge, clear KEY_HELD, EVT_*, FRAME_ERR, the bit count, the shift register, the tick divider and the timeout counter to 0, set the decoder to IDLE, and set the synchroniser and previous-clock flops to 1.
REQ-029 SHALL give RESET priority over every other event, including a frame completing in the same cycle; a frame in progress when reset asserts is discarded.

Verification
REQ-030 SHALL verify: frame 1D (good parity) -> one EVT_VALID, CODE=1D, EXT=0, REL=0, HIT=1, INDEX=4, KEY_HELD[4]=1.
REQ-031 SHALL verify: F0,1D after that -> one event, REL=1, KEY_HELD[4]=0; no event is emitted for F0.
REQ-032 SHALL verify: E0,75 -> HIT=1, INDEX=0, KEY_HELD[0]=1; plain 75 -> HIT=0, KEY_HELD unchanged.
REQ-033 SHALL verify: frame 1D with the parity bit flipped -> FRAME_ERR pulses once, no EVT_VALID, KEY_HELD unchanged; E0 followed by a bad frame, then 75 -> EXT=0.
REQ-034 SHALL verify: 5 bits sent, then idle for more than TIMEOUT_TICKS ticks, then a full 29 frame -> a single event with CODE=29 and INDEX=16, and no FRAME_ERR.
REQ-035 SHALL verify: RESET asserted mid-frame with KEY_HELD=0x00011 -> KEY_HELD=0 and no event; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver and key-state tracker.
// Samples the keyboard clock/data on a slow tick, assembles 11-bit frames,
// decodes E0/F0 prefixed scan codes into make/break events and keeps a
// held/released bit for each of the 17 mapped keys.

module ps2_key_tracker #(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        PS2_KBCLK,
    input  logic        PS2_KBDAT,
    output logic [16:0] KEY_HELD,
    output logic        EVT_VALID,
    output logic [7:0]  EVT_CODE,
    output logic        EVT_EXT,
    output logic        EVT_RELEASE,
    output logic        EVT_HIT,
    output logic [4:0]  EVT_INDEX,
    output logic        FRAME_ERR
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // Key map: entry i matches when both its extended flag and code agree.
    localparam logic [16:0] MAP_EXT = 17'b0_0000_0000_0000_1111;
    localparam logic [16:0][7:0] MAP_CODE = {
        8'h29, 8'h52, 8'h4C, 8'h4B, 8'h4D, 8'h3B, 8'h33, 8'h34, 8'h35,
        8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h74, 8'h6B, 8'h72, 8'h75
    };

    // Synchroniser and divider state.
    logic [1:0]       r_clkSync;
    logic [1:0]       r_datSync;
    logic [DIV_W-1:0] r_divCnt;
    logic             w_tick;
    logic             w_kbClk;
    logic             w_kbDat;
    logic             w_fall;

    // Frame receiver state.
    logic             r_prevClk;
    logic [3:0]       r_bitCnt;
    logic [10:0]      r_shift;
    logic [TO_W-1:0]  r_timeoutCnt;
    logic             r_frameDone;
    logic [10:0]      w_frame;
    logic             w_frameOk;
    logic             w_byteValid;
    logic [7:0]       w_byte;

    // Decoder and event state.
    logic [1:0]       r_state;
    logic [16:0]      r_keyHeld;
    logic             r_evtValid;
    logic [7:0]       r_evtCode;
    logic             r_evtExt;
    logic             r_evtRelease;
    logic             r_evtHit;
    logic [4:0]       r_evtIndex;
    logic             w_isExt;
    logic             w_isBrk;
    logic             w_hit;
    logic [4:0]       w_index;
    logic [16:0]      w_hitMask;

    // Bring the asynchronous keyboard lines into the CLOCK_50 domain; idle level is high.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_clkSync <= 2'b11;
            r_datSync <= 2'b11;
        end else begin
            r_clkSync <= {r_clkSync[0], PS2_KBCLK};
            r_datSync <= {r_datSync[0], PS2_KBDAT};
        end
    end

    assign w_kbClk = r_clkSync[1];
    assign w_kbDat = r_datSync[1];

    // Free-running divider producing one sample tick every CLK_DIV cycles.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_divCnt <= '0;
        end else if (w_tick) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    assign w_tick  = (r_divCnt == DIV_W'(CLK_DIV - 1));
    assign w_fall  = w_tick && r_prevClk && !w_kbClk;
    assign w_frame = {w_kbDat, r_shift[10:1]};

    // Shift bits in on keyboard falling edges, flag frame completion and drop stale partial frames.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_prevClk    <= 1'b1;
            r_bitCnt     <= 4'd0;
            r_shift      <= 11'd0;
            r_timeoutCnt <= '0;
            r_frameDone  <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_tick) begin
                r_prevClk <= w_kbClk;
                if (w_fall) begin
                    r_shift      <= w_frame;
                    r_timeoutCnt <= '0;
                    if (r_bitCnt == 4'd10) begin
                        r_bitCnt    <= 4'd0;
                        r_frameDone <= 1'b1;
                    end else begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                end else if (r_bitCnt != 4'd0) begin
                    if (r_timeoutCnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                        r_bitCnt     <= 4'd0;
                        r_timeoutCnt <= '0;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + TO_W'(1);
                    end
                end
            end
        end
    end

    // A completed frame is good with start low, stop high and odd parity over data plus parity.
    assign w_frameOk   = !r_shift[0] && r_shift[10] && (^r_shift[9:1]);
    assign w_byteValid = r_frameDone && w_frameOk;
    assign w_byte      = r_shift[8:1];
    assign FRAME_ERR   = r_frameDone && !w_frameOk;

    assign w_isExt = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_isBrk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

    // Look up the pending byte plus the current extended flag in the key map.
    always_comb begin
        w_hit     = 1'b0;
        w_index   = 5'd0;
        w_hitMask = 17'd0;
        for (int i = 0; i < 17; i++) begin
            if ((MAP_EXT[i] == w_isExt) && (MAP_CODE[i] == w_byte)) begin
                w_hit        = 1'b1;
                w_index      = 5'(i);
                w_hitMask[i] = 1'b1;
            end
        end
    end

    // Prefix decoder: track E0/F0 prefixes, emit events for other bytes and update key state.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_keyHeld    <= 17'd0;
            r_evtValid   <= 1'b0;
            r_evtCode    <= 8'd0;
            r_evtExt     <= 1'b0;
            r_evtRelease <= 1'b0;
            r_evtHit     <= 1'b0;
            r_evtIndex   <= 5'd0;
        end else begin
            r_evtValid <= 1'b0;
            if (FRAME_ERR) begin
                r_state <= ST_IDLE;
            end else if (w_byteValid) begin
                if (w_byte == CODE_EXT) begin
                    r_state <= ST_EXT;
                end else if (w_byte == CODE_BRK) begin
                    if (r_state == ST_IDLE) begin
                        r_state <= ST_BRK;
                    end else if (r_state == ST_EXT) begin
                        r_state <= ST_EXT_BRK;
                    end
                end else begin
                    r_evtValid   <= 1'b1;
                    r_evtCode    <= w_byte;
                    r_evtExt     <= w_isExt;
                    r_evtRelease <= w_isBrk;
                    r_evtHit     <= w_hit;
                    r_evtIndex   <= w_hit ? w_index : 5'd0;
                    if (w_hit) begin
                        if (w_isBrk) begin
                            r_keyHeld <= r_keyHeld & ~w_hitMask;
                        end else begin
                            r_keyHeld <= r_keyHeld | w_hitMask;
                        end
                    end
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign KEY_HELD    = r_keyHeld;
    assign EVT_VALID   = r_evtValid;
    assign EVT_CODE    = r_evtCode;
    assign EVT_EXT     = r_evtExt;
    assign EVT_RELEASE = r_evtRelease;
    assign EVT_HIT     = r_evtHit;
    assign EVT_INDEX   = r_evtIndex;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard testbench for ps2_key_tracker.
// Stimulus tasks serialise PS/2 frames and push expected events from a
// prefix-flag reference model; a negedge monitor pops and compares them.

module tb_ps2_key_tracker;

    localparam int CLK_DIV       = 4;
    localparam int TIMEOUT_TICKS = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2Clk = 1'b1;
    logic        ps2Dat = 1'b1;
    logic [16:0] keyHeld;
    logic        evtValid;
    logic [7:0]  evtCode;
    logic        evtExt;
    logic        evtRelease;
    logic        evtHit;
    logic [4:0]  evtIndex;
    logic        frameErr;

    typedef struct {
        logic [7:0]  code;
        logic        ext;
        logic        rel;
        logic        hit;
        logic [4:0]  index;
        logic [16:0] held;
    } evt_t;

    evt_t expQ[$];

    int tests = 0;
    int failures = 0;
    int expErrors = 0;
    int seenErrors = 0;

    bit          modelExt = 1'b0;
    bit          modelBrk = 1'b0;
    logic [16:0] modelHeld = 17'd0;

    int mapCode [17] = '{'h75, 'h72, 'h6B, 'h74, 'h1D, 'h1C, 'h1B, 'h23, 'h35,
                         'h34, 'h33, 'h3B, 'h4D, 'h4B, 'h4C, 'h52, 'h29};

    ps2_key_tracker #(
        .CLK_DIV       (CLK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .CLOCK_50    (clock),
        .RESET       (reset),
        .PS2_KBCLK   (ps2Clk),
        .PS2_KBDAT   (ps2Dat),
        .KEY_HELD    (keyHeld),
        .EVT_VALID   (evtValid),
        .EVT_CODE    (evtCode),
        .EVT_EXT     (evtExt),
        .EVT_RELEASE (evtRelease),
        .EVT_HIT     (evtHit),
        .EVT_INDEX   (evtIndex),
        .FRAME_ERR   (frameErr)
    );

    // 100 MHz-style free-running clock.
    always #5 clock = ~clock;

    // Global watchdog so the bench can never hang.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Map index of (ext, code), or -1 when the key is not mapped.
    function automatic int lookup(input bit ext, input logic [7:0] code);
        for (int i = 0; i < 17; i++) begin
            if ((mapCode[i] == int'(code)) && (ext == (i < 4))) return i;
        end
        return -1;
    endfunction

    // kind: 0 good, 1 parity flipped, 2 start high, 3 stop low.
    function automatic logic [10:0] buildFrame(input logic [7:0] data, input int kind);
        logic par;
        logic startBit;
        logic stopBit;
        par      = ~^data;
        startBit = 1'b0;
        stopBit  = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) startBit = 1'b1;
        if (kind == 3) stopBit = 1'b0;
        return {stopBit, par, data, startBit};
    endfunction

    // Reference model: a received byte updates prefix flags or produces an event.
    task automatic modelByte(input logic [7:0] data, input bit good);
        int   idx;
        evt_t e;
        if (!good) begin
            expErrors++;
            modelExt = 1'b0;
            modelBrk = 1'b0;
        end else if (data == 8'hE0) begin
            modelExt = 1'b1;
            modelBrk = 1'b0;
        end else if (data == 8'hF0) begin
            modelBrk = 1'b1;
        end else begin
            idx = lookup(modelExt, data);
            if (idx >= 0) modelHeld[idx] = !modelBrk;
            e.code  = data;
            e.ext   = modelExt;
            e.rel   = modelBrk;
            e.hit   = (idx >= 0);
            e.index = (idx >= 0) ? 5'(idx) : 5'd0;
            e.held  = modelHeld;
            expQ.push_back(e);
            modelExt = 1'b0;
            modelBrk = 1'b0;
        end
    endtask

    task automatic sendBits(input logic [10:0] bits, input int nBits, input int halfTicks);
        for (int i = 0; i < nBits; i++) begin
            ps2Dat = bits[i];
            waitCycles(halfTicks * CLK_DIV);
            ps2Clk = 1'b0;
            waitCycles(halfTicks * CLK_DIV);
            ps2Clk = 1'b1;
        end
        ps2Dat = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int kind, input int halfTicks);
        modelByte(data, kind == 0);
        sendBits(buildFrame(data, kind), 11, halfTicks);
        waitCycles(3 * halfTicks * CLK_DIV);
    endtask

    // Monitor: every event pulse is matched against the oldest expected event.
    always @(negedge clock) begin
        if (!reset) begin
            if (frameErr) seenErrors++;
            if (evtValid) begin
                if (expQ.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected event: got code 0x%0h, expected none", evtCode);
                end else begin
                    evt_t e;
                    e = expQ.pop_front();
                    checkOutput("evt code", 32'(evtCode), 32'(e.code));
                    checkOutput("evt ext", 32'(evtExt), 32'(e.ext));
                    checkOutput("evt release", 32'(evtRelease), 32'(e.rel));
                    checkOutput("evt hit", 32'(evtHit), 32'(e.hit));
                    checkOutput("evt index", 32'(evtIndex), 32'(e.index));
                    checkOutput("evt key held", 32'(keyHeld), 32'(e.held));
                end
            end
        end
    end

    initial begin
        int kind;
        int pick;
        logic [7:0] data;
        logic [10:0] partial;

        reset = 1'b1;
        waitCycles(5);
        checkOutput("reset key held", 32'(keyHeld), 32'h0);
        checkOutput("reset evt valid", 32'(evtValid), 32'h0);
        checkOutput("reset frame err", 32'(frameErr), 32'h0);
        checkOutput("reset evt code", 32'(evtCode), 32'h0);
        reset = 1'b0;
        waitCycles(10);

        // Plain make and break of key 4.
        applyStimulus(8'h1D, 0, 3);
        checkOutput("make 1D held[4]", 32'(keyHeld[4]), 32'h1);
        checkOutput("code held between pulses", 32'(evtCode), 32'h1D);
        applyStimulus(8'hF0, 0, 3);
        applyStimulus(8'h1D, 0, 3);
        checkOutput("break 1D held[4]", 32'(keyHeld[4]), 32'h0);

        // Extended hit versus plain miss for 75.
        applyStimulus(8'hE0, 0, 3);
        applyStimulus(8'h75, 0, 3);
        checkOutput("E0 75 held[0]", 32'(keyHeld[0]), 32'h1);
        applyStimulus(8'h75, 0, 3);
        checkOutput("plain 75 held", 32'(keyHeld), 32'h1);

        // Bad parity, then prefix cleared by a bad frame.
        applyStimulus(8'h1D, 1, 3);
        checkOutput("bad parity held", 32'(keyHeld), 32'h1);
        checkOutput("bad parity err count", 32'(seenErrors), 32'(expErrors));
        applyStimulus(8'hE0, 0, 3);
        applyStimulus(8'h33, 3, 3);
        applyStimulus(8'h75, 0, 3);

        // Partial frame abandoned by timeout, then a full frame.
        partial = buildFrame(8'h29, 0);
        sendBits(partial, 5, 3);
        waitCycles((TIMEOUT_TICKS + 10) * CLK_DIV);
        applyStimulus(8'h29, 0, 3);
        checkOutput("timeout err count", 32'(seenErrors), 32'(expErrors));
        checkOutput("timeout held[16]", 32'(keyHeld[16]), 32'h1);

        // Reset mid-frame with keys 0 and 4 held.
        applyStimulus(8'hF0, 0, 3);
        applyStimulus(8'h29, 0, 3);
        applyStimulus(8'h1D, 0, 3);
        checkOutput("pre-reset held", 32'(keyHeld), 32'h11);
        sendBits(buildFrame(8'h1C, 0), 5, 3);
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        modelExt  = 1'b0;
        modelBrk  = 1'b0;
        modelHeld = 17'd0;
        waitCycles(20);
        checkOutput("post-reset held", 32'(keyHeld), 32'h0);
        applyStimulus(8'h1C, 0, 3);
        checkOutput("after reset held[5]", 32'(keyHeld[5]), 32'h1);

        // Randomised byte stream with occasional corrupted frames.
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 20)      data = 8'hE0;
            else if (pick < 40) data = 8'hF0;
            else if (pick < 85) data = 8'(mapCode[$urandom_range(0, 16)]);
            else                data = 8'($urandom_range(0, 255));
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(data, kind, int'($urandom_range(2, 4)));
        end

        for (int w = 0; w < 2000 && expQ.size() != 0; w++) waitCycles(1);
        checkOutput("events drained", 32'(expQ.size()), 32'h0);
        checkOutput("frame err total", 32'(seenErrors), 32'(expErrors));
        checkOutput("final held", 32'(keyHeld), 32'(modelHeld));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
